// File: rtl/satatb_rxlock.sv
// satatb_rxlock: SATA rx word-alignment/lock controller; `define SATATB_RXLOCK_STATS_EN adds error/slip counters
module satatb_rxlock #(
  parameter logic [31:0] ALIGN_PRIM   = 32'h7b4a4abc,
  parameter int          HUNT_TIMEOUT = 64,
  parameter int          SLIP_WAIT    = 8,
  parameter int          LOCK_COUNT   = 4,
  parameter int          ERR_THRESH   = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic        S_ILLEGAL,
  input  logic        S_CTRL,
  input  logic [31:0] S_DATA,
  output logic        o_slip,
  output logic [5:0]  o_slip_pos,
  output logic        o_locked,
  output logic        o_lost_lock,
  output logic        M_VALID,
  output logic        M_CTRL,
  output logic [31:0] M_DATA
`ifdef SATATB_RXLOCK_STATS_EN
  ,
  output logic [15:0] o_err_count,
  output logic [15:0] o_slip_count
`endif
);
  localparam int TW = $clog2(HUNT_TIMEOUT + 1);
  localparam int AW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(HUNT_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(HUNT_TIMEOUT);
  localparam logic [AW-1:0] AL_MAX  = AW'(LOCK_COUNT);
  localparam logic [WW-1:0] WT_LAST = WW'(SLIP_WAIT - 1);
  localparam logic [3:0]    ER_MAX  = 4'(ERR_THRESH);
  typedef enum logic [2:0] {ST_HUNT, ST_SLIP, ST_WAIT, ST_CHECK, ST_LOCKED} state_t;
  state_t state, nxt;
  logic [TW-1:0] to_cnt, to_n;
  logic [AW-1:0] al_cnt, al_n;
  logic [WW-1:0] wt_cnt, wt_n;
  logic [3:0]    er_cnt, er_n;
  logic          hit, bad;
  assign hit      = S_VALID && S_CTRL && !S_ILLEGAL && S_DATA == ALIGN_PRIM;
  assign bad      = S_VALID && S_ILLEGAL;
  assign S_READY  = 1'b1;
  assign o_locked = state == ST_LOCKED;
  always_comb begin
    nxt  = state;
    to_n = to_cnt;
    al_n = al_cnt;
    wt_n = wt_cnt;
    er_n = er_cnt;
    case (state)
      ST_HUNT:
        if (hit) begin
          nxt  = LOCK_COUNT == 1 ? ST_LOCKED : ST_CHECK;
          al_n = AW'(1);
          to_n = '0;
          er_n = '0;
        end else if (bad || (S_VALID && to_cnt == TO_LAST)) nxt = ST_SLIP;
        else if (S_VALID) to_n = to_cnt + 1'b1;
      ST_SLIP: begin
        nxt  = ST_WAIT;
        wt_n = '0;
      end
      ST_WAIT:
        if (wt_cnt == WT_LAST) begin
          nxt  = ST_HUNT;
          to_n = '0;
        end else wt_n = wt_cnt + 1'b1;
      ST_CHECK:
        if (bad) nxt = ST_SLIP;
        else if (hit) begin
          al_n = al_cnt + 1'b1;
          to_n = '0;
          if (al_n == AL_MAX) begin
            nxt  = ST_LOCKED;
            er_n = '0;
          end
        end else if (S_VALID) begin
          to_n = to_cnt + 1'b1;
          if (to_n == TO_MAX) nxt = ST_SLIP;
        end
      ST_LOCKED:
        if (bad) begin
          er_n = er_cnt + 1'b1;
          if (er_n == ER_MAX) begin
            nxt  = ST_HUNT;
            to_n = '0;
            er_n = '0;
          end
        end else if (hit && er_cnt != 4'd0) er_n = er_cnt - 1'b1;
      default: nxt = ST_HUNT;
    endcase
  end
  // slip pulse and position update together on entry to SLIP, so o_slip_pos only moves with o_slip
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= ST_HUNT;
      to_cnt      <= '0;
      al_cnt      <= '0;
      wt_cnt      <= '0;
      er_cnt      <= '0;
      o_slip      <= 1'b0;
      o_slip_pos  <= '0;
      o_lost_lock <= 1'b0;
      M_VALID     <= 1'b0;
      M_CTRL      <= 1'b0;
      M_DATA      <= '0;
    end else begin
      state       <= nxt;
      to_cnt      <= to_n;
      al_cnt      <= al_n;
      wt_cnt      <= wt_n;
      er_cnt      <= er_n;
      o_slip      <= nxt == ST_SLIP;
      o_lost_lock <= state == ST_LOCKED && nxt == ST_HUNT;
      M_VALID     <= S_VALID && state == ST_LOCKED;
      if (nxt == ST_SLIP) o_slip_pos <= o_slip_pos == 6'd39 ? 6'd0 : o_slip_pos + 6'd1;
      if (S_VALID) begin
        M_CTRL <= S_CTRL;
        M_DATA <= S_DATA;
      end
    end
  end
`ifdef SATATB_RXLOCK_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_err_count  <= '0;
      o_slip_count <= '0;
    end else begin
      if (state == ST_LOCKED && bad && o_err_count != 16'hffff) o_err_count <= o_err_count + 16'd1;
      if (nxt == ST_SLIP && o_slip_count != 16'hffff) o_slip_count <= o_slip_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_satatb_rxlock.sv
// tb_satatb_rxlock: directed bench for satatb_rxlock with hand-computed expectations
module tb_satatb_rxlock;
  localparam logic [31:0] AL = 32'h7b4a4abc;
  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        S_VALID = 1'b0, S_ILLEGAL = 1'b0, S_CTRL = 1'b0;
  logic [31:0] S_DATA = '0;
  logic        S_READY, o_slip, o_locked, o_lost_lock, M_VALID, M_CTRL;
  logic [5:0]  o_slip_pos;
  logic [31:0] M_DATA;
`ifdef SATATB_RXLOCK_STATS_EN
  logic [15:0] o_err_count, o_slip_count;
`endif
  int n_cmp = 0, n_bad = 0;
  logic seen;
  always #5 clk = ~clk;
  satatb_rxlock dut (
    .i_clk(clk), .i_reset(i_reset), .S_VALID(S_VALID), .S_READY(S_READY),
    .S_ILLEGAL(S_ILLEGAL), .S_CTRL(S_CTRL), .S_DATA(S_DATA),
    .o_slip(o_slip), .o_slip_pos(o_slip_pos), .o_locked(o_locked), .o_lost_lock(o_lost_lock),
    .M_VALID(M_VALID), .M_CTRL(M_CTRL), .M_DATA(M_DATA)
`ifdef SATATB_RXLOCK_STATS_EN
    , .o_err_count(o_err_count), .o_slip_count(o_slip_count)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic word(input logic v, input logic il, input logic c, input logic [31:0] d);
    S_VALID = v; S_ILLEGAL = il; S_CTRL = c; S_DATA = d;
    @(posedge clk);
    #1;
  endtask
  task automatic align_w();
    word(1'b1, 1'b0, 1'b1, AL);
  endtask
  task automatic data_w(input logic [31:0] d);
    word(1'b1, 1'b0, 1'b0, d);
  endtask
  task automatic bad_w(input logic [31:0] d);
    word(1'b1, 1'b1, 1'b0, d);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) word(1'b0, 1'b0, 1'b0, 32'h0);
  endtask
  task automatic do_reset();
    i_reset = 1'b1;
    idle(2);
    i_reset = 1'b0;
  endtask
  initial begin
    do_reset();
    chk("rst_slip", 32'(o_slip), 0);
    chk("rst_pos", 32'(o_slip_pos), 0);
    chk("rst_locked", 32'(o_locked), 0);
    chk("rst_lost", 32'(o_lost_lock), 0);
    chk("rst_mvalid", 32'(M_VALID), 0);
    chk("rst_mdata", M_DATA, 0);
    chk("rst_ready", 32'(S_READY), 1);
    // ALIGN on words 1,5,9,13 locks on word 13
    seen = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      if (i % 4 == 1) align_w(); else data_w(32'h100 + i);
      seen |= o_slip;
      if (i == 12) chk("unlocked_w12", 32'(o_locked), 0);
    end
    chk("locked_w13", 32'(o_locked), 1);
    chk("mvalid_w13", 32'(M_VALID), 0);
    data_w(32'habcd0014);
    chk("mvalid_w14", 32'(M_VALID), 1);
    chk("mdata_w14", M_DATA, 32'habcd0014);
    chk("mctrl_w14", 32'(M_CTRL), 0);
    chk("no_slip_lock", 32'(seen), 0);
    // illegal words interleaved with ALIGNs leak away
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bad_w(32'hdead0000 + i);
      seen |= o_lost_lock;
      align_w();
      seen |= o_lost_lock;
    end
    chk("leaky_locked", 32'(o_locked), 1);
    chk("leaky_nolost", 32'(seen), 0);
    chk("mctrl_align", 32'(M_CTRL), 1);
    for (int k = 1; k <= 4; k++) begin
      bad_w(32'hbad00000 + k);
      if (k < 4) chk("err_hold", 32'(o_locked), 1);
    end
    chk("loss_locked", 32'(o_locked), 0);
    chk("loss_pulse", 32'(o_lost_lock), 1);
    chk("loss_fwd_valid", 32'(M_VALID), 1);
    chk("loss_fwd_data", M_DATA, 32'hbad00004);
    idle(1);
    chk("loss_pulse_end", 32'(o_lost_lock), 0);
    data_w(32'h5555);
    chk("post_loss_mvalid", 32'(M_VALID), 0);
    chk("post_loss_noslip", 32'(o_slip), 0);
    // HUNT timeout, then inputs ignored through slip + wait window
    do_reset();
    seen = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      data_w(32'h2000 + i);
      seen |= o_slip;
    end
    chk("to_noslip63", 32'(seen), 0);
    data_w(32'h2040);
    chk("to_slip", 32'(o_slip), 1);
    chk("to_pos", 32'(o_slip_pos), 1);
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      align_w();
      seen |= o_slip;
    end
    chk("win_noslip", 32'(seen), 0);
    chk("win_pos", 32'(o_slip_pos), 1);
    for (int i = 0; i < 3; i++) align_w();
    chk("win_ign_3", 32'(o_locked), 0);
    align_w();
    chk("win_ign_4", 32'(o_locked), 1);
    // 40 slips wrap the position
    do_reset();
    for (int k = 0; k < 40; k++) begin
      bad_w(32'h3000 + k);
      chk("wrap_pos", 32'(o_slip_pos), (k + 1) % 40);
      idle(9);
    end
    // illegal during CHECK slips back to HUNT
    align_w();
    data_w(32'h4001);
    align_w();
    bad_w(32'h4002);
    chk("chk_slip", 32'(o_slip), 1);
    chk("chk_pos", 32'(o_slip_pos), 1);
    chk("chk_unlocked", 32'(o_locked), 0);
    idle(9);
    align_w();
    i_reset = 1'b1;
    align_w();
    i_reset = 1'b0;
    chk("mid_rst_pos", 32'(o_slip_pos), 0);
    chk("mid_rst_slip", 32'(o_slip), 0);
    chk("mid_rst_locked", 32'(o_locked), 0);
    chk("mid_rst_mdata", M_DATA, 0);
    chk("mid_rst_mctrl", 32'(M_CTRL), 0);
    chk("mid_rst_mvalid", 32'(M_VALID), 0);
`ifdef SATATB_RXLOCK_STATS_EN
    for (int k = 0; k < 3; k++) begin
      bad_w(32'h5000 + k);
      idle(9);
    end
    for (int i = 0; i < 4; i++) align_w();
    bad_w(32'h6001);
    bad_w(32'h6002);
    chk("stat_locked", 32'(o_locked), 1);
    chk("stat_slips", 32'(o_slip_count), 3);
    chk("stat_errs", 32'(o_err_count), 2);
    do_reset();
    chk("stat_rst_slips", 32'(o_slip_count), 0);
    chk("stat_rst_errs", 32'(o_err_count), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
